// File: rtl/wb_cmd_pkg.sv
// Shared encodings for the Wishbone command initiator and its sequencer.
// Op codes, FSM states and the RMW merge helper.
package wb_cmd_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_RMW  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RESP = 3'd4
    } state_e;

    localparam logic [3:0] BE_ALL = 4'hF;

    function automatic logic [31:0] rmw_merge(
        input logic [31:0] rd,
        input logic [31:0] set,
        input logic [31:0] mask
    );
        return (rd & ~mask) | (set & mask);
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// No-ACK watchdog: counts strobe cycles without acknowledge.
// LIMIT=0 removes the counter entirely.
module wb_timeout_cnt #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;

    if (LIMIT == 0) begin : g_off
        logic unused_cnt;
        assign unused_cnt = clk_i ^ rst_ni ^ clr_i ^ en_i;
        assign expired_o  = 1'b0;
    end else begin : g_cnt
        logic [W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_i) begin
                cnt_d = '0;
            end else if (en_i && cnt_q != W'(LIMIT)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        // fires on the edge that would make the count reach LIMIT
        assign expired_o = en_i && (cnt_q == W'(LIMIT - 1));
    end

endmodule

// File: rtl/wb_cmd_initiator.sv
// Wishbone initiator turning read/write/RMW commands into bus cycles,
// with a no-ACK timeout and a held response channel.
module wb_cmd_initiator
    import wb_cmd_pkg::*;
#(
    parameter int unsigned ADR_WIDTH      = 17,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'hFABD_EFAC
) (
    input  logic                 WBs_CLK_i,
    input  logic                 WBs_RST_n_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [1:0]           cmd_op_i,
    input  logic [ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [31:0]          cmd_dat_i,
    input  logic [31:0]          cmd_mask_i,
    input  logic [3:0]           cmd_be_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [31:0]          rsp_dat_o,
    output logic                 rsp_err_o,
    output logic [ADR_WIDTH-1:0] WBm_ADR_o,
    output logic                 WBm_CYC_o,
    output logic                 WBm_STB_o,
    output logic                 WBm_WE_o,
    output logic [3:0]           WBm_BYTE_STB_o,
    output logic [31:0]          WBm_DAT_o,
    input  logic [31:0]          WBm_DAT_i,
    input  logic                 WBm_ACK_i
);

    localparam logic [ADR_WIDTH-1:0] ADR_MASK =
        {{(ADR_WIDTH-2){1'b1}}, 2'b00};

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [31:0]            mask_q, mask_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic                   cyc_q, cyc_d;
    logic                   stb_q, stb_d;
    logic                   we_q, we_d;
    logic [3:0]             sel_q, sel_d;
    logic [31:0]            dat_q, dat_d;
    logic [31:0]            rsp_dat_q, rsp_dat_d;
    logic                   rsp_err_q, rsp_err_d;

    logic ack;
    logic expired;
    logic to_clr;
    logic to_en;

    // an ACK outside an active strobe is never looked at
    assign ack    = WBm_ACK_i & stb_q;
    assign to_clr = stb_d & ~stb_q;
    assign to_en  = stb_q & ~WBm_ACK_i;

    wb_timeout_cnt #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (WBs_CLK_i),
        .rst_ni    (WBs_RST_n_i),
        .clr_i     (to_clr),
        .en_i      (to_en),
        .expired_o (expired)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        mask_d    = mask_q;
        adr_d     = adr_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    op_d      = op_e'(cmd_op_i);
                    mask_d    = cmd_mask_i;
                    adr_d     = cmd_adr_i & ADR_MASK;
                    dat_d     = cmd_dat_i;
                    rsp_dat_d = '0;
                    rsp_err_d = 1'b0;
                    unique case (op_e'(cmd_op_i))
                        OP_RD, OP_RMW: begin
                            state_d = ST_RD;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            we_d    = 1'b0;
                            sel_d   = BE_ALL;
                        end
                        OP_WR: begin
                            state_d = ST_WR;
                            cyc_d   = 1'b1;
                            stb_d   = 1'b1;
                            we_d    = 1'b1;
                            sel_d   = cmd_be_i;
                        end
                        default: begin
                            state_d   = ST_RESP;
                            rsp_err_d = 1'b1;
                            rsp_dat_d = ERR_DATA;
                        end
                    endcase
                end
            end
            ST_RD: begin
                if (ack) begin
                    rsp_dat_d = WBm_DAT_i;
                    stb_d     = 1'b0;
                    if (op_q == OP_RMW) begin
                        state_d = ST_GAP;
                    end else begin
                        state_d = ST_RESP;
                        cyc_d   = 1'b0;
                    end
                end else if (expired) begin
                    state_d   = ST_RESP;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = ERR_DATA;
                end
            end
            ST_GAP: begin
                // rsp_dat_q holds the pre-modify value read in ST_RD
                state_d = ST_WR;
                stb_d   = 1'b1;
                we_d    = 1'b1;
                sel_d   = BE_ALL;
                dat_d   = rmw_merge(rsp_dat_q, dat_q, mask_q);
            end
            ST_WR: begin
                if (ack) begin
                    state_d = ST_RESP;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                end else if (expired) begin
                    state_d   = ST_RESP;
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = ERR_DATA;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
        if (!WBs_RST_n_i) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_RD;
            mask_q    <= '0;
            adr_q     <= '0;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            mask_q    <= mask_d;
            adr_q     <= adr_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    assign cmd_ready_o    = (state_q == ST_IDLE);
    assign rsp_valid_o    = (state_q == ST_RESP);
    assign rsp_dat_o      = rsp_dat_q;
    assign rsp_err_o      = rsp_err_q;
    assign WBm_ADR_o      = adr_q;
    assign WBm_CYC_o      = cyc_q;
    assign WBm_STB_o      = stb_q;
    assign WBm_WE_o       = we_q;
    assign WBm_BYTE_STB_o = sel_q;
    assign WBm_DAT_o      = dat_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator: register-array slave BFM,
// reference register model and a response scoreboard queue.
module tb_wb_cmd_initiator;
    import wb_cmd_pkg::*;

    localparam int unsigned TO = 8;
    localparam logic [31:0] ERRD = 32'hFABD_EFAC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [16:0] cmd_adr;
    logic [31:0] cmd_dat, cmd_mask;
    logic [3:0]  cmd_be;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [16:0] adr;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] wdat, rdat;
    logic        ack;

    always #5 clk = ~clk;

    wb_cmd_initiator #(
        .ADR_WIDTH      (17),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .WBs_CLK_i      (clk),
        .WBs_RST_n_i    (rst_n),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_op_i       (cmd_op),
        .cmd_adr_i      (cmd_adr),
        .cmd_dat_i      (cmd_dat),
        .cmd_mask_i     (cmd_mask),
        .cmd_be_i       (cmd_be),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_dat_o      (rsp_dat),
        .rsp_err_o      (rsp_err),
        .WBm_ADR_o      (adr),
        .WBm_CYC_o      (cyc),
        .WBm_STB_o      (stb),
        .WBm_WE_o       (we),
        .WBm_BYTE_STB_o (sel),
        .WBm_DAT_o      (wdat),
        .WBm_DAT_i      (rdat),
        .WBm_ACK_i      (ack)
    );

    // slave BFM: window 0x1000-0x10FF, registered ACK gated by ~ACK
    logic        ack_q;
    logic        stray = 1'b0;
    logic [31:0] mem [64];
    logic        s_map;
    logic [5:0]  s_idx;

    assign s_map = (adr[16:8] == 9'h010);
    assign s_idx = adr[7:2];
    assign rdat  = mem[s_idx];
    assign ack   = ack_q | stray;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_q <= 1'b0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            ack_q <= cyc & stb & ~ack_q & s_map;
            if (cyc & stb & ack_q & we) begin
                for (int b = 0; b < 4; b++)
                    if (sel[b]) mem[s_idx][8*b +: 8] <= wdat[8*b +: 8];
            end
        end
    end

    // bus monitor
    int          ecnt = 0;
    int          stb_hi = 0, stb_rise = 0, gap_n = 0, cyc_fall = 0;
    logic        pstb = 1'b0, pcyc = 1'b0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = '0;
    logic [31:0] last_dat = '0;

    always @(posedge clk) ecnt <= ecnt + 1;

    always @(negedge clk) begin
        pstb <= stb;
        pcyc <= cyc;
        if (stb) begin
            stb_hi   <= stb_hi + 1;
            last_we  <= we;
            last_sel <= sel;
            last_dat <= wdat;
        end
        if (stb && !pstb) stb_rise <= stb_rise + 1;
        if (cyc && !stb) gap_n <= gap_n + 1;
        if (!cyc && pcyc) cyc_fall <= cyc_fall + 1;
    end

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
        int          edges;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [64];
    int          total = 0, bad = 0;
    int          d_hi, d_rise, d_gap, d_fall;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [16:0] a,
                          input logic [31:0] d, input logic [31:0] m,
                          input logic [3:0] be, input int hold,
                          input bit poke, input string tag);
        exp_t e;
        int   n, t0, s_hi, s_rise, s_gap, s_fall;
        logic map;
        logic [5:0] ix;
        bit   ok;
        map = (a[16:8] == 9'h010);
        ix  = a[7:2];
        e.err = 1'b0;
        e.dat = '0;
        if (op == 2'b11) begin
            e.err = 1'b1; e.dat = ERRD; e.edges = 0;
        end else if (!map) begin
            e.err = 1'b1; e.dat = ERRD; e.edges = int'(TO);
        end else if (op == 2'b00) begin
            e.dat = model[ix]; e.edges = 2;
        end else if (op == 2'b01) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model[ix][8*b +: 8] = d[8*b +: 8];
            e.edges = 2;
        end else begin
            e.dat = model[ix];
            model[ix] = (model[ix] & ~m) | (d & m);
            e.edges = 5;
        end
        sb.push_back(e);
        n = 0;
        while (!cmd_ready && n < 50) begin tick; n++; end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        s_hi = stb_hi; s_rise = stb_rise; s_gap = gap_n; s_fall = cyc_fall;
        cmd_valid = 1'b1; cmd_op = op; cmd_adr = a;
        cmd_dat = d; cmd_mask = m; cmd_be = be;
        @(posedge clk);
        #1;
        t0 = ecnt;
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_adr = 17'($urandom);
        cmd_dat = $urandom; cmd_mask = $urandom; cmd_be = 4'($urandom);
        tick;
        n = 0;
        while (!rsp_valid && n < 40) begin tick; n++; end
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        e = sb.pop_front();
        check({tag, "_rsp_dat"}, rsp_dat, e.dat);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'(e.err));
        // rsp_valid seen after edge T0+k, i.e. in cycle T0+k+1
        check({tag, "_latency"}, 32'(ecnt - t0), 32'(e.edges));
        if (hold > 0) begin
            ok = 1'b1;
            cmd_valid = 1'b1; cmd_op = 2'b01; cmd_adr = 17'h0_1010;
            cmd_dat = 32'h1234_5678; cmd_be = 4'hF;
            for (int i = 0; i < hold; i++) begin
                tick;
                if (!rsp_valid || rsp_dat !== e.dat || rsp_err !== e.err ||
                    cmd_ready || stb || cyc) ok = 1'b0;
            end
            cmd_valid = 1'b0;
            check({tag, "_hold_stable"}, 32'(ok), 32'd1);
        end
        if (poke) begin
            stray = 1'b1;
            tick;
            stray = 1'b0;
            tick;
            ok = rsp_valid && rsp_dat === e.dat && rsp_err === e.err && !stb;
            check({tag, "_stray_ack"}, 32'(ok), 32'd1);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        tick;
        check({tag, "_idle"}, {30'd0, cmd_ready, rsp_valid}, 32'd2);
        d_hi = stb_hi - s_hi; d_rise = stb_rise - s_rise;
        d_gap = gap_n - s_gap; d_fall = cyc_fall - s_fall;
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0;
        cmd_dat = '0; cmd_mask = '0; cmd_be = '0; rsp_ready = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        repeat (3) tick;
        check("rst_ctl", {26'd0, cmd_ready, rsp_valid, rsp_err, cyc, stb, we},
              32'h20);
        check("rst_bus", {11'd0, adr, sel}, 32'd0);
        check("rst_dat", wdat | rsp_dat, 32'd0);
        rst_n = 1'b1;
        tick;

        do_cmd(2'b01, 17'h0_1004, 32'h0000_00A5, '0, 4'h1, 0, 0, "wr");
        check("wr_stb_cycles", 32'(d_hi), 32'd2);
        check("wr_stb_pulses", 32'(d_rise), 32'd1);
        check("wr_reg", mem[1], 32'h0000_00A5);
        check("wr_we_sel", {27'd0, last_we, last_sel}, 32'h11);

        do_cmd(2'b00, 17'h0_1004, '0, '0, '0, 0, 0, "rd");
        check("rd_we_sel", {27'd0, last_we, last_sel}, 32'h0F);
        check("rd_adr", 32'(adr), 32'h0_1004);

        do_cmd(2'b01, 17'h0_1008, 32'hFFFF_0000, '0, 4'hF, 0, 0, "pre");
        do_cmd(2'b10, 17'h0_1008, 32'h0000_0012, 32'h0000_00FF, '0, 0, 0,
               "rmw");
        check("rmw_reg", mem[2], 32'hFFFF_0012);
        check("rmw_model", mem[2], model[2]);
        check("rmw_wdat", last_dat, 32'hFFFF_0012);
        check("rmw_cyc_falls", 32'(d_fall), 32'd1);
        check("rmw_gap", 32'(d_gap), 32'd1);
        check("rmw_pulses", 32'(d_rise), 32'd2);

        do_cmd(2'b00, 17'h1_0000, '0, '0, '0, 0, 1, "to");
        check("to_stb_cycles", 32'(d_hi), 32'd8);

        do_cmd(2'b00, 17'h0_1008, '0, '0, '0, 10, 0, "hold");
        do_cmd(2'b01, 17'h0_100E, 32'hDEAD_BEEF, '0, 4'hF, 0, 0, "wr2");
        check("wr2_reg", mem[3], 32'hDEAD_BEEF);
        do_cmd(2'b00, 17'h0_100C, '0, '0, '0, 0, 0, "rd2");

        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_adr = 17'h0_1004;
        cmd_dat = 32'h0000_0F00; cmd_mask = 32'h0000_FF00; cmd_be = '0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        while (!(cyc && !stb) && n < 20) begin tick; n++; end
        check("gap_reached", {30'd0, cyc, stb}, 32'd2);
        rst_n = 1'b0;
        #1;
        check("arst_ctl", {28'd0, cyc, stb, rsp_valid, cmd_ready}, 32'd1);
        for (int i = 0; i < 64; i++) model[i] = '0;
        tick;
        rst_n = 1'b1;
        tick;
        do_cmd(2'b11, 17'h0_1004, '0, '0, '0, 0, 0, "rsvd");
        check("rsvd_no_stb", 32'(d_rise), 32'd0);
        do_cmd(2'b00, 17'h0_1004, '0, '0, '0, 0, 0, "rd3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
